// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard
//   Tracks in-flight destination registers for the stages after ID
//   (entry 0 = EX, 1 = MEM, 2 = WB, ...). From these entries it produces
//   the load-use stall for ID and the EX-stage forwarding selects. The
//   selects are registered at the same edge that moves the ID instruction
//   into EX.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   id_*              decoded fields of the instruction currently in ID
//   flush             branch taken in MEM; kills the youngest FLUSH_DEPTH
//                     entries and turns the ID issue into a bubble
//   stall             combinational; hold PC and IF/ID, zero ID/EX control
//   ex_fwd_a/b        operand source in EX: 0 = ID/EX value,
//                     k = result register at the end of stage k
//   busy              any scoreboard entry valid
//   stall_cnt,        only when HAZARD_STATS_EN is defined: saturating
//   flush_cnt         counts of stall cycles and flush cycles
//
// Optional feature macro: HAZARD_STATS_EN
module mips_hazard_scoreboard #(
   parameter int DEPTH       = 3,
   parameter int RADDR_W     = 5,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int SEL_W       = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic               id_rs_used,
   input  logic               id_rt_used,
   input  logic               id_wr_en,
   input  logic [RADDR_W-1:0] id_wr_addr,
   input  logic               id_is_load,
   input  logic               flush,
   output logic               stall,
   output logic [SEL_W-1:0]   ex_fwd_a,
   output logic [SEL_W-1:0]   ex_fwd_b,
   output logic               busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   typedef struct packed {
      logic               valid;
      logic [RADDR_W-1:0] wr_addr;
      logic               is_load;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
   logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

   logic             haz_a, haz_b;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic             issue;

   // Source lookup. Scanning oldest to youngest lets the youngest match win.
   // A producer that has reached the last entry is being written back this
   // cycle; the write-first regfile already supplies it, hence select 0.
   always_comb begin
      haz_a = 1'b0;
      haz_b = 1'b0;
      sel_a = '0;
      sel_b = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (id_rs_used && id_rs != '0 && ent_q[i].valid && ent_q[i].wr_addr == id_rs) begin
            haz_a = ent_q[i].is_load && (i < LOAD_LAT);
            sel_a = (i < DEPTH - 1) ? SEL_W'(i + 1) : '0;
         end
         if (id_rt_used && id_rt != '0 && ent_q[i].valid && ent_q[i].wr_addr == id_rt) begin
            haz_b = ent_q[i].is_load && (i < LOAD_LAT);
            sel_b = (i < DEPTH - 1) ? SEL_W'(i + 1) : '0;
         end
      end
   end

   // A flush wins over a stall: the consumer in ID is being discarded.
   assign stall = (haz_a || haz_b) && id_valid && !flush && !reset;
   assign issue = id_valid && !stall && !flush;

   always_comb begin
      ent_d[0] = '0;
      // r0 is never recorded, so reads of r0 can never match.
      if (issue && id_wr_en && id_wr_addr != '0)
         ent_d[0] = '{valid: 1'b1, wr_addr: id_wr_addr, is_load: id_is_load};
      // Older entries keep advancing during a stall; only the issue is a bubble.
      for (int i = 1; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i-1];
         if (flush && (i - 1) < FLUSH_DEPTH)
            ent_d[i].valid = 1'b0;
      end
      fwd_a_d = issue ? sel_a : '0;
      fwd_b_d = issue ? sel_b : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= ent_d[i];
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign ex_fwd_a = fwd_a_q;
   assign ex_fwd_b = fwd_b_q;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         busy = busy | ent_q[i].valid;
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != 32'hFFFF_FFFF)
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Testbench for mips_hazard_scoreboard at default parameters
// (DEPTH=3, LOAD_LAT=1, FLUSH_DEPTH=1). Directed scenarios use hand-derived
// constants; the random run is compared against a producer-list model in
// which each in-flight writer carries its age in stages since issue.
module tb_mips_hazard_scoreboard;
   localparam int DEPTH       = 3;
   localparam int RADDR_W     = 5;
   localparam int LOAD_LAT    = 1;
   localparam int FLUSH_DEPTH = 1;
   localparam int SEL_W       = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               id_valid;
   logic [RADDR_W-1:0] id_rs, id_rt, id_wr_addr;
   logic               id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
   logic               stall, busy;
   logic [SEL_W-1:0]   ex_fwd_a, ex_fwd_b;
`ifdef HAZARD_STATS_EN
   logic [31:0]        stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   mips_hazard_scoreboard #(
      .DEPTH(DEPTH), .RADDR_W(RADDR_W), .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
      .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .busy(busy)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   int checks = 0;
   int failures = 0;

   // Reference model: list of in-flight register writers with their age.
   typedef struct {
      logic [RADDR_W-1:0] addr;
      logic               ld;
      int                 stg;
   } prod_t;
   prod_t prods[$];
   longint m_stall_cnt, m_flush_cnt;

   // Observed (o_*) and expected (e_*) values of the last step.
   logic             o_stall, o_busy_pre, o_busy;
   logic [SEL_W-1:0] o_fa, o_fb;
   logic             e_stall, e_busy_pre, e_busy;
   logic [SEL_W-1:0] e_fa, e_fb;
   longint           o_sc, o_fc;

   // One clock: drive ID fields after a falling edge, sample the
   // combinational outputs, cross the rising edge, sample registered outputs.
   task automatic step(input logic v, input logic [RADDR_W-1:0] rs, input logic [RADDR_W-1:0] rt,
                       input logic ru, input logic tu, input logic we,
                       input logic [RADDR_W-1:0] wa, input logic ld,
                       input logic fl, input logic rst);
      int  sa, sb;
      bit  la, lb, iss;
      prod_t nq[$];
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
      id_wr_en = we; id_wr_addr = wa; id_is_load = ld; flush = fl; reset = rst;
      #1;
      o_stall = stall; o_busy_pre = busy;
      sa = -1; sb = -1; la = 0; lb = 0;
      foreach (prods[i]) begin
         if (ru && rs != 0 && prods[i].addr == rs && (sa < 0 || prods[i].stg < sa)) begin
            sa = prods[i].stg; la = prods[i].ld;
         end
         if (tu && rt != 0 && prods[i].addr == rt && (sb < 0 || prods[i].stg < sb)) begin
            sb = prods[i].stg; lb = prods[i].ld;
         end
      end
      e_stall = ((sa >= 0 && la && sa < LOAD_LAT) || (sb >= 0 && lb && sb < LOAD_LAT))
                && v && !fl && !rst;
      e_busy_pre = prods.size() != 0;
      iss  = v && !e_stall && !fl && !rst;
      e_fa = (iss && sa >= 0 && sa + 1 <= DEPTH - 1) ? SEL_W'(sa + 1) : '0;
      e_fb = (iss && sb >= 0 && sb + 1 <= DEPTH - 1) ? SEL_W'(sb + 1) : '0;
      if (rst) begin
         prods.delete();
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         foreach (prods[i])
            if (!(fl && prods[i].stg < FLUSH_DEPTH) && prods[i].stg + 1 < DEPTH)
               nq.push_back('{addr: prods[i].addr, ld: prods[i].ld, stg: prods[i].stg + 1});
         if (iss && we && wa != 0)
            nq.push_back('{addr: wa, ld: ld, stg: 0});
         prods = nq;
         if (e_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
         if (fl && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
      end
      e_busy = prods.size() != 0;
      @(posedge clk);
      #1;
      o_fa = ex_fwd_a; o_fb = ex_fwd_b; o_busy = busy;
`ifdef HAZARD_STATS_EN
      o_sc = stall_cnt; o_fc = flush_cnt;
`else
      o_sc = m_stall_cnt; o_fc = m_flush_cnt;
`endif
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset();
      step(1, 5, 6, 1, 1, 1, 5, 1, 0, 1);
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", o_stall); end
      checks++; if (o_fa !== 2'd0 || o_fb !== 2'd0) begin failures++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", o_fa, o_fb); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", o_busy); end
   endtask

   task automatic test_fwd_alu();
      do_reset();
      step(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);          // add r3,r1,r2
      step(1, 3, 4, 1, 1, 1, 8, 0, 0, 0);          // sub r8,r3,r4
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0d exp=0", o_stall); end
      checks++; if (o_fa !== 2'd1) begin failures++; $display("FAIL alu_fwd_a got=%0d exp=1", o_fa); end
      checks++; if (o_fb !== 2'd0) begin failures++; $display("FAIL alu_fwd_b got=%0d exp=0", o_fb); end
      idle(3);
   endtask

   task automatic test_load_use();
      int stalls = 0;
      do_reset();
      step(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);          // lw r5
      step(1, 5, 7, 1, 1, 1, 6, 0, 0, 0);          // add r6,r5,r7 (stalls)
      stalls += o_stall;
      checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", o_stall); end
      checks++; if (o_fa !== 2'd0 || o_fb !== 2'd0) begin failures++; $display("FAIL lu_bubble_fwd got=%0d/%0d exp=0/0", o_fa, o_fb); end
      step(1, 5, 7, 1, 1, 1, 6, 0, 0, 0);          // add reissued
      stalls += o_stall;
      checks++; if (stalls != 1) begin failures++; $display("FAIL lu_stall_len got=%0d exp=1", stalls); end
      checks++; if (o_fa !== 2'd2 || o_fb !== 2'd0) begin failures++; $display("FAIL lu_fwd got=%0d/%0d exp=2/0", o_fa, o_fb); end
      idle(3);
   endtask

   task automatic test_load_gap();
      do_reset();
      step(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);          // lw r5
      step(1, 1, 2, 1, 1, 1, 9, 0, 0, 0);          // or r9
      step(1, 5, 2, 1, 1, 1, 6, 0, 0, 0);          // add r6,r5,r2
      checks++; if (o_stall !== 1'b0 || o_fa !== 2'd2) begin failures++; $display("FAIL gap1 got stall=%0d fa=%0d exp stall=0 fa=2", o_stall, o_fa); end
      do_reset();
      step(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);          // lw r5
      step(1, 1, 2, 1, 1, 1, 9, 0, 0, 0);
      step(1, 1, 2, 1, 1, 1, 10, 0, 0, 0);
      step(1, 2, 5, 1, 1, 1, 6, 0, 0, 0);          // reads r5 as rt, 3 later
      checks++; if (o_stall !== 1'b0 || o_fb !== 2'd0) begin failures++; $display("FAIL gap3 got stall=%0d fb=%0d exp stall=0 fb=0", o_stall, o_fb); end
      idle(3);
   endtask

   task automatic test_r0();
      do_reset();
      step(1, 1, 2, 1, 1, 1, 0, 1, 0, 0);          // lw r0
      step(1, 1, 2, 1, 1, 1, 0, 0, 0, 0);          // add r0
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL r0_busy got=%0d exp=0", o_busy); end
      step(1, 0, 0, 1, 1, 1, 11, 0, 0, 0);         // reads r0, writes r11
      checks++; if (o_stall !== 1'b0 || o_fa !== 2'd0 || o_fb !== 2'd0) begin failures++; $display("FAIL r0_read got stall=%0d fa=%0d fb=%0d exp 0/0/0", o_stall, o_fa, o_fb); end
      checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL r0_busy_prod got=%0d exp=1", o_busy); end
      idle(3);
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL r0_drain got=%0d exp=0", o_busy); end
   endtask

   task automatic test_flush();
      do_reset();
      step(1, 1, 0, 1, 0, 1, 5, 1, 0, 0);          // lw r5
      step(1, 5, 0, 1, 0, 1, 6, 0, 1, 0);          // consumer with flush
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%0d exp=0", o_stall); end
      checks++; if (o_fa !== 2'd0 || o_fb !== 2'd0) begin failures++; $display("FAIL fl_fwd got=%0d/%0d exp=0/0", o_fa, o_fb); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL fl_busy got=%0d exp=0", o_busy); end
`ifdef HAZARD_STATS_EN
      checks++; if (o_fc != 1 || o_sc != 0) begin failures++; $display("FAIL fl_cnt got fc=%0d sc=%0d exp fc=1 sc=0", o_fc, o_sc); end
`endif
      idle(3);
   endtask

   task automatic test_youngest_reset();
      do_reset();
      step(1, 1, 2, 1, 1, 1, 4, 0, 0, 0);          // add r4
      step(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);          // lw r4
      step(1, 4, 0, 1, 0, 1, 7, 0, 0, 0);          // consumer r4
      checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL yg_stall got=%0d exp=1", o_stall); end
      step(1, 4, 0, 1, 0, 1, 7, 0, 0, 0);
      checks++; if (o_stall !== 1'b0 || o_fa !== 2'd2) begin failures++; $display("FAIL yg_fwd got stall=%0d fa=%0d exp stall=0 fa=2", o_stall, o_fa); end
      do_reset();
      step(1, 1, 2, 1, 1, 1, 4, 0, 0, 0);
      step(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);
      step(1, 4, 0, 1, 0, 1, 7, 0, 0, 1);          // reset during the stall
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL yg_rst_stall got=%0d exp=0", o_stall); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL yg_rst_busy got=%0d exp=0", o_busy); end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [RADDR_W-1:0] rs, rt, wa;
         logic v, ru, tu, we, ld, fl, rst;
         rs = RADDR_W'($urandom_range(7)); rt = RADDR_W'($urandom_range(7));
         wa = RADDR_W'($urandom_range(7));
         v = ($urandom_range(9) != 0); ru = ($urandom_range(3) != 0); tu = ($urandom_range(1) != 0);
         we = ($urandom_range(4) != 0); ld = ($urandom_range(2) == 0);
         fl = ($urandom_range(9) == 0); rst = ($urandom_range(59) == 0);
         step(v, rs, rt, ru, tu, we, wa, ld, fl, rst);
         checks++;
         if (o_stall !== e_stall || o_busy_pre !== e_busy_pre || o_fa !== e_fa || o_fb !== e_fb
             || o_busy !== e_busy || o_sc != m_stall_cnt || o_fc != m_flush_cnt) begin
            failures++; bad++;
            if (bad <= 10)
               $display("FAIL rand cyc=%0d got stall=%0d busy=%0d/%0d fa=%0d fb=%0d sc=%0d fc=%0d exp stall=%0d busy=%0d/%0d fa=%0d fb=%0d sc=%0d fc=%0d",
                        n, o_stall, o_busy_pre, o_busy, o_fa, o_fb, o_sc, o_fc,
                        e_stall, e_busy_pre, e_busy, e_fa, e_fb, m_stall_cnt, m_flush_cnt);
         end
      end
   endtask

   initial begin
      m_stall_cnt = 0; m_flush_cnt = 0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_wr_en = 0; id_wr_addr = 0; id_is_load = 0; flush = 0; reset = 1;
      @(negedge clk);
      do_reset();
      test_reset();
      test_fwd_alu();
      test_load_use();
      test_load_gap();
      test_r0();
      test_flush();
      test_youngest_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
